// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way resource arbiter: sizes and FSM state encoding.
package arb_pkg;
    localparam int N_REQ  = 16;
    localparam int ID_W   = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;
endpackage

// File: rtl/resource_arbiter16_if.sv
// Request/grant bundle between the clients (master) and the arbiter (slave).
interface resource_arbiter16_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_id, grant_valid, timeout
    );
endinterface

// File: rtl/rr_pick16.sv
// Rotated priority encoder: highest set bit wins after rotating req by the pointer,
// so the search runs p-1, p-2, ... down to p. With rr=0 the rotation is zero.
module rr_pick16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  p,
    input  logic             rr,
    output logic             any,
    output logic [ID_W-1:0]  id
);
    logic [ID_W-1:0]  sh;
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  hi;

    assign sh = rr ? p : '0;

    for (genvar j = 0; j < N_REQ; j++) begin : g_rot
        logic [ID_W-1:0] src;
        assign src    = ID_W'(j) + sh;
        assign rot[j] = req[src];
    end

    always_comb begin
        hi = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rot[j]) hi = ID_W'(j);
        end
    end

    assign any = |req;
    assign id  = hi + sh;
endmodule

// File: rtl/resource_arbiter16.sv
// Single-grant arbiter: IDLE picks a winner, GRANT holds until done/abandon/limit,
// GAP inserts one dead cycle before the next pick.
module resource_arbiter16
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter bit RR       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    resource_arbiter16_if.slave  bus
);
    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;

    logic              pick_any;
    logic [ID_W-1:0]   pick_id;

    rr_pick16 u_pick (
        .req (bus.req),
        .p   (ptr_q),
        .rr  (RR),
        .any (pick_any),
        .id  (pick_id)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                    ptr_d         = pick_id;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                cnt_d = (cnt_q == {HOLD_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                // done outranks both abandon and the hold limit
                if (bus.done || !bus.req[grant_id_q] ||
                    (cnt_q == HOLD_W'(HOLD_MAX - 1))) begin
                    timeout_d     = !bus.done && bus.req[grant_id_q];
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    state_d       = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_resource_arbiter16.sv
// Table-driven bench: dut_a is fixed priority with HOLD_MAX=3, dut_b is round-robin
// with HOLD_MAX=15. Expected outputs are queued per step and popped after each edge.
module tb_resource_arbiter16;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [15:0] req;
        logic        done;
        logic [15:0] g;
        logic [3:0]  id;
        logic        v;
        logic        to;
    } step_t;

    typedef struct packed {
        logic [15:0] grant;
        logic [3:0]  id;
        logic        v;
        logic        to;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    resource_arbiter16_if a_if ();
    resource_arbiter16_if b_if ();

    resource_arbiter16 #(.HOLD_MAX(3), .RR(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    resource_arbiter16 #(.HOLD_MAX(15), .RR(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    task automatic test_reset();
        step_t s [0:4];
        exp_t  e, x;
        s = '{
            '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'hFFFF, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            rst_n = s[i].rst_n;
            a_if.req = s[i].req; a_if.done = s[i].done;
            b_if.req = s[i].req; b_if.done = s[i].done;
            x = {s[i].g, s[i].id, s[i].v, s[i].to};
            qa.push_back(x);
            qb.push_back(x);
            @(posedge clk); #1;
            e = qa.pop_front();
            checks++;
            if ({a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout} !== e) begin
                errors++;
                $display("FAIL reset_a step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout, e.grant, e.id, e.v, e.to);
            end
            e = qb.pop_front();
            checks++;
            if ({b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout} !== e) begin
                errors++;
                $display("FAIL reset_b step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // Fixed priority: 4 beats 1, and stays the winner after the gap.
    task automatic test_fixed();
        step_t s [0:6];
        exp_t  e;
        s = '{
            '{1'b1, 16'h0012, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0},
            '{1'b1, 16'h0012, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0},
            '{1'b1, 16'h0012, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0012, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0012, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            rst_n = s[i].rst_n; a_if.req = s[i].req; a_if.done = s[i].done;
            qa.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qa.pop_front();
            checks++;
            if ({a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout} !== e) begin
                errors++;
                $display("FAIL fixed step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // HOLD_MAX=3: grant for exactly 3 cycles, timeout in the gap, then re-grant.
    task automatic test_hold_limit();
        step_t s [0:7];
        exp_t  e;
        s = '{
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b1},
            '{1'b1, 16'h0080, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            rst_n = s[i].rst_n; a_if.req = s[i].req; a_if.done = s[i].done;
            qa.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qa.pop_front();
            checks++;
            if ({a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout} !== e) begin
                errors++;
                $display("FAIL hold step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // Dropping req[7] mid-grant releases without timeout; client 0 wins next.
    task automatic test_abandon();
        step_t s [0:5];
        exp_t  e;
        s = '{
            '{1'b1, 16'h0081, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0001, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0001, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            rst_n = s[i].rst_n; a_if.req = s[i].req; a_if.done = s[i].done;
            qa.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qa.pop_front();
            checks++;
            if ({a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout} !== e) begin
                errors++;
                $display("FAIL abandon step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // done on the limit cycle wins: release with no timeout pulse.
    task automatic test_conflict();
        step_t s [0:5];
        exp_t  e;
        s = '{
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0},
            '{1'b1, 16'h0080, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            rst_n = s[i].rst_n; a_if.req = s[i].req; a_if.done = s[i].done;
            qa.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qa.pop_front();
            checks++;
            if ({a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout} !== e) begin
                errors++;
                $display("FAIL conflict step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // Round-robin from a fresh pointer with req=8011: 15, 4, 0, 15.
    task automatic test_round_robin();
        step_t s [0:12];
        exp_t  e;
        s = '{
            '{1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0},
            '{1'b1, 16'h8011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0},
            '{1'b1, 16'h8011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0},
            '{1'b1, 16'h8011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            rst_n = s[i].rst_n; b_if.req = s[i].req; b_if.done = s[i].done;
            qb.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qb.pop_front();
            checks++;
            if ({b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout} !== e) begin
                errors++;
                $display("FAIL rr step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    // Pointer left at 15 picks 4 from 0011; reset mid-grant must restore p=0 so 15 wins.
    task automatic test_reset_mid_grant();
        step_t s [0:4];
        exp_t  e;
        s = '{
            '{1'b1, 16'h0011, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0},
            '{1'b0, 16'h0011, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h8011, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0},
            '{1'b1, 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0},
            '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            rst_n = s[i].rst_n; b_if.req = s[i].req; b_if.done = s[i].done;
            qb.push_back({s[i].g, s[i].id, s[i].v, s[i].to});
            @(posedge clk); #1;
            e = qb.pop_front();
            checks++;
            if ({b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout} !== e) begin
                errors++;
                $display("FAIL rst_mid step %0d: got g=%h id=%0d v=%b to=%b, want g=%h id=%0d v=%b to=%b",
                         i, b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout, e.grant, e.id, e.v, e.to);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.req = '0; a_if.done = 1'b0;
        b_if.req = '0; b_if.done = 1'b0;
        test_reset();
        test_fixed();
        test_hold_limit();
        test_abandon();
        test_conflict();
        test_round_robin();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/resource_arbiter16.md
# resource_arbiter16

Sequential 16-requester arbiter that shares one downstream resource among up to 16 clients, built around a priority-encoder pick. It grants exactly one requester at a time, holds the grant until the client signals `done`, the client drops its request, or a hold limit expires, and then inserts one idle gap cycle. It selects either by fixed priority (highest index wins) or by round-robin rotation, and it reports the winner as both a one-hot vector and a 4-bit index.

## Interface
- `HOLD_MAX`, 15: maximum number of cycles a grant may stay high. Legal range is 1..255.
- `RR`, 1: selection mode. 1 selects round-robin, 0 selects fixed priority (index 15 highest).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low. Single clock domain.
- `req`  in  16  request lines; `req[i]` high means client i wants the resource.
- `done`  in  1  the granted client releases the resource; sampled only in GRANT.
- `grant`  out  16  one-hot grant, registered.
- `grant_id`  out  4  index of the granted client, registered; valid when `grant_valid` is high.
- `grant_valid`  out  1  high whenever `grant` is nonzero.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- **FSM states:** IDLE, GRANT, GAP.
- **IDLE:**
  - If `req` is nonzero at the edge, pick a winner w, set `grant = 1<<w`, `grant_id = w`, `grant_valid = 1`, clear the hold counter, and go to GRANT.
  - Otherwise stay in IDLE with all outputs 0.
- **GRANT:** the hold counter increments every cycle. At each edge, evaluate in this priority order:
  1. If `done` is high, release and go to GAP. `timeout` stays 0.
  2. Else if `req[grant_id]` is 0 (abandon), release and go to GAP. `timeout` stays 0.
  3. Else if the counter equals `HOLD_MAX-1`, release, go to GAP, and set `timeout = 1` for one cycle.
  4. Else stay in GRANT.
- **Release:** `grant`, `grant_valid` and `grant_id` all go to 0 at the release edge.
- **GAP:** one cycle with all outputs 0, then IDLE. Requests seen during GAP are ignored.
- **Fixed mode (RR=0):** the winner is the highest set index of `req`.
- **Round-robin mode (RR=1):**
  - A pointer p holds the last winner; reset value is 0.
  - Search order is p-1, p-2, …, 0, 15, …, p, wrapping mod 16.
  - p updates to w on each new grant.
  - Because p resets to 0, the first search order is 15..0, identical to fixed mode.
- **Arithmetic:**
  - The hold counter is 8 bits, saturating, and compared against `HOLD_MAX-1`.
  - Pointer arithmetic is 4-bit and wraps naturally.
- **Output invariants:**
  - `grant` is never multi-hot.
  - `grant_valid` equals `|grant`.
  - `timeout` never coincides with `grant_valid`.
- **Reset:** when `rst_n` is 0 at an edge:
  - State returns to IDLE.
  - `grant`, `grant_id`, `grant_valid`, `timeout`, the counter and p are all cleared.
  - This applies mid-grant too; there is no completion and no timeout pulse.

## Timing
- **Request to grant latency:** 1 edge. A `req` present before edge k gives `grant` high after edge k.
- **Grant lifetime:**
  - At most `HOLD_MAX` cycles.
  - With `done` held from the first GRANT cycle, `grant` is high for exactly 1 cycle.
- **Back-to-back:** minimum spacing between two grants is grant duration + 1 GAP cycle + 1 IDLE evaluation edge. The IDLE edge that evaluates `req` also issues the grant.
- **`timeout`:** high during the single GAP cycle that follows a limit release.
- **Simultaneous events:**
  - `done` and the limit together: `done` wins, no pulse.
  - `done` and abandon together: treated as `done`.
- **Inputs:** `req` and `done` are synchronous to `clk`; the block has no internal synchronizers.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ = 16`
  - `ID_W = 4`
  - state enum `arb_state_t {IDLE, GRANT, GAP}`
- **Sub-module `rr_pick16`:**
  - Combinational rotated priority encoder.
  - Inputs: `req[15:0]`, pointer `p[3:0]`, `rr` mode.
  - Outputs: `any`, `id[3:0]`.
  - Implementation: rotate `req` by p, take the highest set bit, un-rotate.
- **Top module:** contains the FSM, hold counter, pointer and output registers.

## Test plan
- **Reset:** apply `rst_n`=0 for 2 cycles with `req`=16'hFFFF → all outputs 0. After release, the next edge gives `grant_id`=15 and `grant`=16'h8000.
- **Fixed priority:** RR=0, `req`=16'h0012, `done` on the 2nd GRANT cycle → `grant_id`=4 for 2 cycles, one GAP cycle, then `grant_id`=4 again (not 1).
- **Round-robin rotation:** RR=1, `req`=16'h8011, `done` pulsed every grant → `grant_id` sequence 15, 4, 0, 15, each grant separated by one GAP cycle.
- **Hold limit:** HOLD_MAX=3, `req[7]` held, `done`=0 → `grant`=16'h0080 for exactly 3 cycles, `timeout`=1 for one cycle, then re-grant to 7.
- **Abandon and conflict:** clearing `req[7]` mid-grant → release next edge with `timeout`=0. `done` asserted on the limit cycle → `timeout`=0.
- **Reset mid-grant:** assert `rst_n`=0 during GRANT → `grant`=0 the next edge, no `timeout`, and the pointer is back to 0 (next pick is the highest index).
